// File: rtl/dice_roll_if.sv
// Handshake bundle between the roll controller and its neighbours: raw button in,
// settled face value and status out.
interface dice_roll_if;
   logic       btn;
   logic [2:0] value;
   logic       valid;
   logic       rolling;
   logic       roll_done;

   modport master (
      output btn,
      input  value,
      input  valid,
      input  rolling,
      input  roll_done
   );

   modport slave (
      input  btn,
      output value,
      output valid,
      output rolling,
      output roll_done
   );
endinterface

// File: rtl/dice_roll_ctrl.sv
// Dice roll controller: button synchroniser/debouncer and roll FSM producing a face 1..6.
// Define SLOW_SETTLE_EN to add the decelerating SETTLING phase after release.
module dice_roll_ctrl #(
   parameter int DEBOUNCE_CYCLES = 1000,
   parameter int ROLL_TICK       = 250,
   parameter int SETTLE_STEPS    = 4
) (
   input  logic       clk,
   input  logic       rst,
   dice_roll_if.slave bus
);

   localparam int TICK_MAX = ROLL_TICK << SETTLE_STEPS;
   localparam int TICK_W   = $clog2(TICK_MAX + 1);
   localparam int DB_W     = $clog2(DEBOUNCE_CYCLES + 1);

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      ROLLING  = 2'd1,
`ifdef SLOW_SETTLE_EN
      SETTLING = 2'd3,
`endif
      SHOW     = 2'd2
   } state_e;

   state_e              state_q, state_d;
   logic                sync0_q, sync0_d;
   logic                sync1_q, sync1_d;
   logic                btn_db_q, btn_db_d;
   logic                btn_db_prev_q, btn_db_prev_d;
   logic [DB_W-1:0]     db_cnt_q, db_cnt_d;
   logic [TICK_W-1:0]   tick_q, tick_d;
   logic [2:0]          value_q, value_d;
   logic                roll_done_q, roll_done_d;
   logic                press, release_ev, tick_last;

`ifdef SLOW_SETTLE_EN
   localparam int STEP_W = $clog2(SETTLE_STEPS + 1);
   logic [STEP_W-1:0]   step_q, step_d;
   logic [TICK_W-1:0]   settle_last;
   // Each settle step doubles the wait: step k waits ROLL_TICK << k cycles.
   assign settle_last = TICK_W'(ROLL_TICK << (int'(step_q) + 1)) - TICK_W'(1);
`endif

   function automatic logic [2:0] next_face(input logic [2:0] f);
      return (f == 3'd6) ? 3'd1 : f + 3'd1;
   endfunction

   assign press      = btn_db_q & ~btn_db_prev_q;
   assign release_ev = ~btn_db_q & btn_db_prev_q;
   assign tick_last  = (tick_q == TICK_W'(ROLL_TICK - 1));

   always_comb begin
      sync0_d       = bus.btn;
      sync1_d       = sync0_q;
      btn_db_d      = btn_db_q;
      btn_db_prev_d = btn_db_q;
      db_cnt_d      = '0;
      state_d       = state_q;
      tick_d        = tick_q;
      value_d       = value_q;
`ifdef SLOW_SETTLE_EN
      step_d        = step_q;
`endif

      if (sync1_q != btn_db_q) begin
         if (db_cnt_q == DB_W'(DEBOUNCE_CYCLES - 1)) begin
            btn_db_d = sync1_q;
         end else begin
            db_cnt_d = db_cnt_q + DB_W'(1);
         end
      end

      case (state_q)
         IDLE: begin
            if (press) begin
               state_d = ROLLING;
               tick_d  = '0;
            end
         end
         ROLLING: begin
            tick_d = tick_q + TICK_W'(1);
            if (tick_last) begin
               value_d = next_face(value_q);
               tick_d  = '0;
            end
            // A tick landing on the release cycle still advances before freezing.
            if (release_ev) begin
`ifdef SLOW_SETTLE_EN
               state_d = SETTLING;
               tick_d  = '0;
               step_d  = '0;
`else
               state_d = SHOW;
`endif
            end
         end
`ifdef SLOW_SETTLE_EN
         SETTLING: begin
            if (press) begin
               state_d = ROLLING;
               tick_d  = '0;
               step_d  = '0;
            end else begin
               tick_d = tick_q + TICK_W'(1);
               if (tick_q == settle_last) begin
                  value_d = next_face(value_q);
                  tick_d  = '0;
                  step_d  = step_q + STEP_W'(1);
                  if (step_q == STEP_W'(SETTLE_STEPS - 1)) begin
                     state_d = SHOW;
                  end
               end
            end
         end
`endif
         SHOW: begin
            if (press) begin
               state_d = ROLLING;
               tick_d  = '0;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      roll_done_d = (state_d == SHOW) && (state_q != SHOW);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= IDLE;
         sync0_q       <= 1'b0;
         sync1_q       <= 1'b0;
         btn_db_q      <= 1'b0;
         btn_db_prev_q <= 1'b0;
         db_cnt_q      <= '0;
         tick_q        <= '0;
         value_q       <= 3'd1;
         roll_done_q   <= 1'b0;
`ifdef SLOW_SETTLE_EN
         step_q        <= '0;
`endif
      end else begin
         state_q       <= state_d;
         sync0_q       <= sync0_d;
         sync1_q       <= sync1_d;
         btn_db_q      <= btn_db_d;
         btn_db_prev_q <= btn_db_prev_d;
         db_cnt_q      <= db_cnt_d;
         tick_q        <= tick_d;
         value_q       <= value_d;
         roll_done_q   <= roll_done_d;
`ifdef SLOW_SETTLE_EN
         step_q        <= step_d;
`endif
      end
   end

   assign bus.value     = value_q;
   assign bus.valid     = (state_q == SHOW);
`ifdef SLOW_SETTLE_EN
   assign bus.rolling   = (state_q == ROLLING) || (state_q == SETTLING);
`else
   assign bus.rolling   = (state_q == ROLLING);
`endif
   assign bus.roll_done = roll_done_q;

endmodule

// File: tb/tb_dice_roll_ctrl.sv
// Scoreboard bench for dice_roll_ctrl: stimulus queues expected face advances and
// roll_done events with their cycle stamps; a negedge monitor pops and compares them.
module tb_dice_roll_ctrl;

   localparam int DEBOUNCE_CYCLES = 4;
   localparam int ROLL_TICK       = 3;
   localparam int SETTLE_STEPS    = 2;

   typedef struct {
      int value;
      int at;
   } ev_t;

   logic clk;
   logic rst;
   int   cyc;
   int   n_cmp;
   int   n_err;
   int   face;
   int   last_value;
   bit   mon_en;
   ev_t  adv_q[$];
   ev_t  done_q[$];

   dice_roll_if bus();

   dice_roll_ctrl #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .ROLL_TICK       (ROLL_TICK),
      .SETTLE_STEPS    (SETTLE_STEPS)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial cyc = 0;
   always @(posedge clk) cyc++;

   task automatic checkOutput(input string name, input int actual, input int expected);
      n_cmp++;
      if (actual != expected) begin
         n_err++;
         $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
      end
   endtask

   task automatic waitCyc(input int t);
      while (cyc < t) @(negedge clk);
   endtask

   task automatic applyStimulus(input int at, input logic level);
      waitCyc(at);
      bus.btn = level;
   endtask

   function automatic int nextFace(input int f);
      return (f == 6) ? 1 : f + 1;
   endfunction

   task automatic pushAdv(input int at);
      ev_t e;
      face    = nextFace(face);
      e.value = face;
      e.at    = at;
      adv_q.push_back(e);
   endtask

   task automatic pushRun(input int base, input int first, input int last);
      for (int t = base + first; t <= base + last; t += ROLL_TICK) pushAdv(t);
   endtask

   task automatic pushDone(input int at);
      ev_t e;
      e.value = face;
      e.at    = at;
      done_q.push_back(e);
   endtask

   task automatic checkState(input string tag, input int v, input int vl, input int rl);
      checkOutput({tag, "_value"}, int'(bus.value), v);
      checkOutput({tag, "_valid"}, int'(bus.valid), vl);
      checkOutput({tag, "_rolling"}, int'(bus.rolling), rl);
   endtask

   // Monitor: every face change and every roll_done pulse must match the next queued event.
   always @(negedge clk) begin
      if (rst || !mon_en) begin
         last_value = int'(bus.value);
      end else begin
         if (int'(bus.value) != last_value) begin
            if (adv_q.size() == 0) begin
               n_cmp++;
               n_err++;
               $display("[TB] FAIL unexpected_adv: got value %0d at cycle %0d, expected none", bus.value, cyc);
            end else begin
               ev_t e;
               e = adv_q.pop_front();
               checkOutput("adv_value", int'(bus.value), e.value);
               checkOutput("adv_cycle", cyc, e.at);
            end
         end
         if (bus.roll_done) begin
            if (done_q.size() == 0) begin
               n_cmp++;
               n_err++;
               $display("[TB] FAIL unexpected_done: got roll_done at cycle %0d, expected none", cyc);
            end else begin
               ev_t e;
               e = done_q.pop_front();
               checkOutput("done_cycle", cyc, e.at);
               checkOutput("done_value", int'(bus.value), e.value);
               checkOutput("done_valid", int'(bus.valid), 1);
               checkOutput("done_rolling", int'(bus.rolling), 0);
            end
         end
         last_value = int'(bus.value);
      end
   end

   initial begin
      int base;
      n_cmp   = 0;
      n_err   = 0;
      face    = 1;
      mon_en  = 1'b0;
      rst     = 1'b1;
      bus.btn = 1'b0;

      // Reset state
      repeat (3) @(negedge clk);
      checkState("reset", 1, 0, 0);
      checkOutput("reset_done", int'(bus.roll_done), 0);
      rst    = 1'b0;
      mon_en = 1'b1;

      // Reset while rolling
      base = cyc;
      applyStimulus(base, 1'b1);
      waitCyc(base + 6);
      checkOutput("pre_roll_rolling", int'(bus.rolling), 0);
      waitCyc(base + 7);
      checkState("roll_start", 1, 0, 1);
      waitCyc(base + 8);
      rst     = 1'b1;
      bus.btn = 1'b0;
      waitCyc(base + 9);
      checkState("midrst", 1, 0, 0);
      checkOutput("midrst_done", int'(bus.roll_done), 0);
      rst = 1'b0;
      waitCyc(base + 20);
      checkState("post_rst", 1, 0, 0);

      // Glitch shorter than the debounce window
      base = cyc;
      applyStimulus(base, 1'b1);
      applyStimulus(base + 3, 1'b0);
      waitCyc(base + 15);
      checkState("glitch", 1, 0, 0);

      // Long roll: 13 advances while held, release on tick boundary+1
      base = cyc;
      pushRun(base, 10, 46);
`ifdef SLOW_SETTLE_EN
      pushAdv(base + 53);
      pushAdv(base + 65);
      pushDone(base + 65);
`else
      pushDone(base + 47);
`endif
      applyStimulus(base, 1'b1);
      applyStimulus(base + 40, 1'b0);
      waitCyc(base + 46);
      checkOutput("long_rolling_46", int'(bus.rolling), 1);
`ifdef SLOW_SETTLE_EN
      waitCyc(base + 47);
      checkState("settle_entry", 2, 0, 1);
      waitCyc(base + 64);
      checkState("settle_last", 3, 0, 1);
      waitCyc(base + 65);
      checkState("settle_show", 4, 1, 0);
      waitCyc(base + 165);
      checkState("long_hold", 4, 1, 0);
`else
      waitCyc(base + 47);
      checkState("long_show", 2, 1, 0);
      waitCyc(base + 147);
      checkState("long_hold", 2, 1, 0);
`endif

`ifdef SLOW_SETTLE_EN
      // Re-press five cycles into SETTLING
      base = cyc;
      pushRun(base, 10, 46);
      pushAdv(base + 53);
      pushRun(base, 62, 68);
      pushAdv(base + 75);
      pushAdv(base + 87);
      pushDone(base + 87);
      applyStimulus(base, 1'b1);
      applyStimulus(base + 40, 1'b0);
      applyStimulus(base + 52, 1'b1);
      waitCyc(base + 60);
      checkOutput("repress_valid", int'(bus.valid), 0);
      checkOutput("repress_rolling", int'(bus.rolling), 1);
      applyStimulus(base + 62, 1'b0);
      waitCyc(base + 107);
      checkState("repress_show", 5, 1, 0);

      // Roll ending on 6: 5 rolling advances then 2 settle advances
      base = cyc;
      pushRun(base, 10, 22);
      pushAdv(base + 28);
      pushAdv(base + 40);
      pushDone(base + 40);
      applyStimulus(base, 1'b1);
      applyStimulus(base + 15, 1'b0);
      waitCyc(base + 60);
`else
      // Roll ending on 6: release coincides with the 4th tick
      base = cyc;
      pushRun(base, 10, 19);
      pushDone(base + 19);
      applyStimulus(base, 1'b1);
      applyStimulus(base + 12, 1'b0);
      waitCyc(base + 40);
`endif
      checkState("six_show", 6, 1, 0);

      // Press from SHOW at 6: valid drops with rolling rise, first advance wraps to 1
      base = cyc;
      pushRun(base, 10, 10);
`ifdef SLOW_SETTLE_EN
      pushAdv(base + 18);
      pushAdv(base + 30);
      pushDone(base + 30);
`else
      pushDone(base + 12);
`endif
      applyStimulus(base, 1'b1);
      applyStimulus(base + 5, 1'b0);
      waitCyc(base + 6);
      checkState("wrap_pre", 6, 1, 0);
      waitCyc(base + 7);
      checkState("wrap_press", 6, 0, 1);
      waitCyc(base + 10);
      checkOutput("wrap_value", int'(bus.value), 1);
      waitCyc(base + 50);
`ifdef SLOW_SETTLE_EN
      checkState("final_show", 3, 1, 0);
`else
      checkState("final_show", 1, 1, 0);
`endif

      checkOutput("adv_left", adv_q.size(), 0);
      checkOutput("done_left", done_q.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/dice_roll_ctrl.md
Name: dice_roll_ctrl

Overview:
Front-end roll controller for the dice roller, directly upstream of the 7-segment decoder. It synchronises and debounces the raw push-button and runs the roll state machine: a fast spin while the button is held, then a freeze on release. It presents a stable face value 1..6 with valid/done status for the decoder and the top level.

Parameters:
DEBOUNCE_CYCLES, 1000, consecutive clk cycles the synchronised button must differ from the debounced level before that level flips (10 us at 100 MHz); legal range >= 1.
ROLL_TICK, 250, clk cycles between face advances while rolling; legal range >= 1.
SETTLE_STEPS, 4, extra face advances after release; used only with SLOW_SETTLE_EN; legal range >= 1.

Ports:
clk  input  1  system clock, 100 MHz nominal.
rst  input  1  synchronous, active-high reset.
btn  input  1  raw push-button, asynchronous to clk, active high.
value  output  3  current face, always 1..6; 0 and 7 are never driven.
valid  output  1  high while value is a settled result.
rolling  output  1  high in ROLLING and SETTLING.
roll_done  output  1  one-cycle pulse on entry to SHOW.

Behaviour:
- One clock. Reset is synchronous and active-high. All flops update only on the rising edge of clk.
- Reset values: value=1, valid=0, rolling=0, roll_done=0, state=IDLE, both synchroniser flops=0, btn_db=0, debounce counter=0, tick counter=0. Reset asserted mid-operation forces all of these on the next edge, whatever the state.
- Input conditioning: a 2-FF synchroniser produces btn_s.
  - The debounce counter increments each cycle that btn_s != btn_db and clears to 0 on any cycle that btn_s == btn_db.
  - When the counter reaches DEBOUNCE_CYCLES-1 with a mismatch still present, btn_db takes btn_s on the next edge and the counter clears.
  - press = rising edge of btn_db; release = falling edge of btn_db. Each is a one-cycle internal event.
- State machine (IDLE, ROLLING, SETTLING, SHOW):
  - IDLE: valid=0, rolling=0. press -> ROLLING.
  - ROLLING: rolling=1, valid=0.
    - The tick counter clears on entry. When it reaches ROLL_TICK-1, value advances and the counter clears.
    - Advance sequence: 1->2->3->4->5->6->1. Wrap from 6 to 1 is mandatory.
    - release -> SETTLING when SLOW_SETTLE_EN is defined, otherwise -> SHOW.
    - If release and a tick terminal count occur in the same cycle, the advance happens first, then the state changes.
  - SETTLING (SLOW_SETTLE_EN only): rolling=1, valid=0.
    - Advance k (k=1..SETTLE_STEPS) occurs ROLL_TICK<<k cycles after the previous advance or after SETTLING entry.
    - After advance SETTLE_STEPS -> SHOW.
    - press during SETTLING -> ROLLING: tick counter cleared, step index cleared, value unchanged.
  - SHOW: valid=1, rolling=0, value held. roll_done=1 only on the first SHOW cycle. press -> ROLLING with valid dropping to 0 on the same edge.
- Widths: the tick counter is sized to hold ROLL_TICK<<SETTLE_STEPS. The debounce counter is sized to hold DEBOUNCE_CYCLES. No counter may overflow.
- Latency: a clean btn edge reaches btn_db DEBOUNCE_CYCLES+2 cycles later (2 synchroniser cycles plus the debounce count). The state change happens on the following edge.

Optional Feature:
SLOW_SETTLE_EN
- Defined: release enters SETTLING, giving SETTLE_STEPS decelerating advances before SHOW.
- Undefined: the SETTLING state and its logic are absent. release goes ROLLING -> SHOW with value frozen at its last ROLLING value, and the SETTLE_STEPS parameter is ignored.

Test Plan:
Bench parameters: DEBOUNCE_CYCLES=4, ROLL_TICK=3, SETTLE_STEPS=2, clk period 10 ns.
1. Reset for 3 cycles with btn=0 -> value=1, valid=0, rolling=0, roll_done=0. Then assert rst for 1 cycle while rolling=1 -> reset values on the next edge.
2. btn high for 3 cycles, then low (glitch) -> btn_db never rises, rolling stays 0, value stays 1.
3. SLOW_SETTLE_EN undefined; btn high 40 cycles, then low -> rolling rises 7 cycles after the btn edge. Value steps every 3 cycles: 2,3,4,5,6,1,... On release, rolling falls, roll_done pulses exactly once, valid=1, and value equals the last ROLLING value and stays stable for 100 cycles.
4. SLOW_SETTLE_EN defined; same stimulus as 3 -> after release, exactly 2 further advances at 6 and then 12 cycles. roll_done occurs 18 cycles after SETTLING entry, with valid=1 from the same cycle.
5. SLOW_SETTLE_EN defined; re-press 5 cycles into SETTLING (clean edge held 10 cycles) -> returns to ROLLING, valid stays 0, no roll_done pulse, value continues advancing from its current face.
6. From SHOW with value=6, press -> valid=0 and rolling=1 on the same edge. The first advance 3 cycles later gives value=1 (wrap).
